sram_queue_scheduler: RTL and testbench



---
 rtl/sram_queue_scheduler.sv | 134 +++++++++++++
 tb/tb_sram_queue_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_queue_scheduler.sv
// Packet-granular round-robin scheduler for the SRAM-backed output queues.
// Grants one queue at a time, follows its packet to end-of-packet, and counts completed packets.
module sram_queue_scheduler #(
    parameter int NUM_QUEUES     = 4,
    parameter int QUEUE_ID_WIDTH = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cal_done,
    input  logic [NUM_QUEUES-1:0]        queue_pkt_avail,
    input  logic [NUM_QUEUES-1:0]        queue_enable,
    input  logic                         out_almost_full,
    output logic                         rd_req,
    output logic [QUEUE_ID_WIDTH-1:0]    rd_queue,
    input  logic                         rd_ack,
    input  logic                         rd_word_valid,
    input  logic                         rd_last_word,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [32*NUM_QUEUES-1:0]     pkt_cnt,
    output logic [31:0]                  total_pkt_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [QUEUE_ID_WIDTH-1:0] LAST_Q = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [QUEUE_ID_WIDTH-1:0]  last_grant;
    logic [CNT_W-1:0]           idle_cnt;
    logic [NUM_QUEUES-1:0]      eligible;
    logic                       found;
    logic [QUEUE_ID_WIDTH-1:0]  sel;
    logic [QUEUE_ID_WIDTH-1:0]  cand;
    logic                       grant_ok;
    logic                       pkt_done;
    logic                       wd_fire;
    logic [31:0]                pkt_cnt_q [NUM_QUEUES];

    assign eligible = queue_pkt_avail & queue_enable;
    assign grant_ok = cal_done && !out_almost_full && found;
    assign pkt_done = (state == XFER) && rd_word_valid && rd_last_word;
    assign wd_fire  = (state == XFER) && !rd_word_valid && (idle_cnt == IDLE_MAX);
    assign busy     = (state != IDLE);

    // Search upward from the queue after the last one served, wrapping at NUM_QUEUES.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            cand = QUEUE_ID_WIDTH'((int'(last_grant) + i) % NUM_QUEUES);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_ok) state_next = REQ;
            REQ:     if (rd_ack) state_next = XFER;
            XFER:    if (pkt_done || wd_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_req      <= 1'b0;
            rd_queue    <= '0;
            last_grant  <= LAST_Q;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        rd_queue <= sel;
                        rd_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (rd_ack) begin
                        rd_req   <= 1'b0;
                        idle_cnt <= '0;
                    end
                end
                XFER: begin
                    if (rd_word_valid) begin
                        idle_cnt <= '0;
                        if (rd_last_word) last_grant <= rd_queue;
                    end else if (idle_cnt == IDLE_MAX) begin
                        // Stuck queue drops to lowest priority for the next round.
                        timeout_err <= 1'b1;
                        last_grant  <= rd_queue;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_pkt_cnt <= '0;
            for (int q = 0; q < NUM_QUEUES; q++) pkt_cnt_q[q] <= '0;
        end else if (pkt_done) begin
            total_pkt_cnt <= total_pkt_cnt + 32'd1;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (rd_queue == QUEUE_ID_WIDTH'(q)) pkt_cnt_q[q] <= pkt_cnt_q[q] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
        assign pkt_cnt[32*g +: 32] = pkt_cnt_q[g];
    end

endmodule

// File: tb/tb_sram_queue_scheduler.sv
// Self-checking bench for sram_queue_scheduler: grant scoreboard, vector table, corner sequences.
module tb_sram_queue_scheduler;

    localparam int NQ = 4;
    localparam int QW = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            cal_done;
    logic [NQ-1:0]   queue_pkt_avail;
    logic [NQ-1:0]   queue_enable;
    logic            out_almost_full;
    logic            rd_req;
    logic [QW-1:0]   rd_queue;
    logic            rd_ack;
    logic            rd_word_valid;
    logic            rd_last_word;
    logic            busy;
    logic            timeout_err;
    logic [32*NQ-1:0] pkt_cnt;
    logic [31:0]     total_pkt_cnt;

    sram_queue_scheduler #(
        .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .cal_done(cal_done),
        .queue_pkt_avail(queue_pkt_avail), .queue_enable(queue_enable),
        .out_almost_full(out_almost_full), .rd_req(rd_req), .rd_queue(rd_queue),
        .rd_ack(rd_ack), .rd_word_valid(rd_word_valid), .rd_last_word(rd_last_word),
        .busy(busy), .timeout_err(timeout_err), .pkt_cnt(pkt_cnt),
        .total_pkt_cnt(total_pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [QW-1:0] sb[$];
    int unsigned model_pkt[NQ];
    int unsigned model_total;

    typedef struct {
        logic [NQ-1:0] avail;
        logic [NQ-1:0] enable;
        int            nwords;
        int            ack_dly;
        logic [QW-1:0] exp_q;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_counters(input string name);
        for (int i = 0; i < NQ; i++)
            check($sformatf("%s_pkt_cnt%0d", name, i), pkt_cnt[32*i +: 32], model_pkt[i]);
        check({name, "_total"}, total_pkt_cnt, model_total);
    endtask

    task automatic get_grant(input string name, output logic [QW-1:0] q, output int lat);
        lat = 0;
        q = '0;
        while (rd_req !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_req"}, rd_req, 1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: got grant with no expectation queued", name);
        end else begin
            q = sb.pop_front();
            check({name, "_queue"}, rd_queue, q);
        end
    endtask

    task automatic xfer(input logic [QW-1:0] q, input int nwords, input int ack_dly);
        for (int d = 0; d < ack_dly; d++) begin
            @(negedge clk);
            check("req_hold", {rd_req, rd_queue}, {1'b1, q});
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check("ack_drop", rd_req, 0);
        check("xfer_busy", busy, 1);
        for (int w = 0; w < nwords; w++) begin
            rd_word_valid = 1'b1;
            rd_last_word  = (w == nwords - 1);
            @(negedge clk);
        end
        rd_word_valid = 1'b0;
        rd_last_word  = 1'b0;
        model_pkt[q]++;
        model_total++;
        check("idle_after_last", {busy, rd_req}, 0);
    endtask

    initial begin
        logic [QW-1:0] q;
        int lat;
        int bad;
        int n;

        vecs[0] = '{4'b1111, 4'b1011, 3, 0, 2'd3};
        vecs[1] = '{4'b1111, 4'b1011, 2, 0, 2'd0};
        vecs[2] = '{4'b1111, 4'b1011, 1, 2, 2'd1};
        vecs[3] = '{4'b1111, 4'b1011, 4, 0, 2'd3};
        vecs[4] = '{4'b1111, 4'b1011, 2, 0, 2'd0};
        vecs[5] = '{4'b0101, 4'b1111, 1, 0, 2'd2};
        vecs[6] = '{4'b1001, 4'b0111, 3, 1, 2'd0};
        vecs[7] = '{4'b1110, 4'b1100, 2, 0, 2'd2};
        vecs[8] = '{4'b1111, 4'b1111, 1, 0, 2'd3};
        vecs[9] = '{4'b0011, 4'b1111, 2, 0, 2'd0};

        for (int i = 0; i < NQ; i++) model_pkt[i] = 0;
        model_total = 0;
        reset = 1'b1; cal_done = 1'b0; queue_pkt_avail = '0; queue_enable = '0;
        out_almost_full = 1'b0; rd_ack = 1'b0; rd_word_valid = 1'b0; rd_last_word = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_rd_req", rd_req, 0);
        check("rst_rd_queue", rd_queue, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        check_counters("rst");

        // Calibration gating, then round robin from queue 0
        queue_pkt_avail = 4'b1111; queue_enable = 4'b1111;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_req !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("cal_gate", bad, 0);
        cal_done = 1'b1;
        sb.push_back(2'd0);
        get_grant("cal_rise", q, lat);
        check("cal_lat", lat, 1);
        xfer(q, 3, 0);
        for (int k = 1; k < 4; k++) begin
            sb.push_back(QW'(k));
            get_grant($sformatf("rr%0d", k), q, lat);
            check($sformatf("rr%0d_gap", k), lat, 1);
            xfer(q, 3, 0);
        end
        check_counters("rr4");
        check("rr4_total_const", total_pkt_cnt, 4);
        sb.push_back(2'd0);
        get_grant("rr_wrap", q, lat);
        xfer(q, 3, 0);

        // Single eligible queue, back-to-back packets
        queue_pkt_avail = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(2'd2);
            get_grant($sformatf("solo%0d", k), q, lat);
            check($sformatf("solo%0d_gap", k), lat, 1);
            xfer(q, 2, 0);
            check($sformatf("solo%0d_total", k), total_pkt_cnt, model_total);
        end

        // Almost-full raised mid packet of queue 1
        queue_pkt_avail = 4'b0010;
        sb.push_back(2'd1);
        get_grant("af", q, lat);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        rd_word_valid = 1'b1;
        @(negedge clk);
        out_almost_full = 1'b1;
        queue_pkt_avail = 4'b1111;
        @(negedge clk);
        rd_last_word = 1'b1;
        @(negedge clk);
        rd_word_valid = 1'b0; rd_last_word = 1'b0;
        model_pkt[1]++; model_total++;
        check_counters("af_done");
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_req !== 1'b0) bad++;
        end
        check("af_gate", bad, 0);
        out_almost_full = 1'b0;
        sb.push_back(2'd2);
        get_grant("af_release", q, lat);
        check("af_release_lat", lat, 1);
        xfer(q, 1, 0);

        // Watchdog: queue 0 granted, never delivers; stray last_word without valid
        queue_pkt_avail = 4'b0001;
        sb.push_back(2'd0);
        get_grant("to", q, lat);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        rd_last_word = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        rd_last_word = 1'b0;
        queue_pkt_avail = 4'b1111;
        check("to_cycles", n, TO);
        check("to_err", timeout_err, 1);
        check_counters("to");
        sb.push_back(2'd1);
        get_grant("to_next", q, lat);
        xfer(q, 2, 0);
        check("to_sticky", timeout_err, 1);

        // Vector table: patterns of avail/enable with hand-derived grants
        for (int i = 0; i < 10; i++) begin
            queue_pkt_avail = vecs[i].avail;
            queue_enable    = vecs[i].enable;
            sb.push_back(vecs[i].exp_q);
            get_grant($sformatf("vec%0d", i), q, lat);
            xfer(q, vecs[i].nwords, vecs[i].ack_dly);
        end
        check_counters("vec");

        // Reset in the middle of a transfer
        queue_pkt_avail = 4'b1111; queue_enable = 4'b1111;
        sb.push_back(2'd1);
        get_grant("mid", q, lat);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        rd_word_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        rd_word_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NQ; i++) model_pkt[i] = 0;
        model_total = 0;
        sb.delete();
        check("mrst_rd_req", rd_req, 0);
        check("mrst_busy", busy, 0);
        check("mrst_timeout", timeout_err, 0);
        check_counters("mrst");
        reset = 1'b0;
        sb.push_back(2'd0);
        get_grant("post_rst", q, lat);
        check("post_rst_lat", lat, 1);
        xfer(q, 2, 0);
        check_counters("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
